restoring_divider: RTL

//   Sequential unsigned restoring divider, the subtract-direction counterpart of
//   the ripple-carry adder datapath. Computes quotient and remainder of

---
 rtl/restoring_divider.sv | 129 ++++++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift-and-trial-subtract step per clock,
// start/busy/done handshake, divide-by-zero flagged and answered in a single cycle.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_last_step;
  logic [WIDTH:0]   w_rem_shifted;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_zero_div  = (divisor == '0);
  assign w_last_step = (r_count == CW'(1));

  // The partial remainder is always below the divisor, so after the shift it fits in
  // WIDTH+1 bits and a set MSB of the trial difference means "would go negative".
  assign w_rem_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_trial       = w_rem_shifted - {1'b0, r_div};
  assign w_rem_nxt     = w_trial[WIDTH] ? w_rem_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt     = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of the order the statements are written in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the next state gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_zero_div ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_step) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the working registers are reset too, not just the visible outputs, so an
  // aborted division leaves no stale operands behind and simulation never sees X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_count       <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_zero_div) begin
          r_quotient    <= '1;
          r_remainder   <= dividend;
          r_div_by_zero <= 1'b1;
        end else begin
          r_rem         <= '0;
          r_quo         <= dividend;
          r_div         <= divisor;
          r_count       <= CW'(WIDTH);
          r_div_by_zero <= 1'b0;
        end
      end else if (r_state == S_RUN) begin
        r_rem   <= w_rem_nxt;
        r_quo   <= w_quo_nxt;
        r_count <= r_count - CW'(1);
        // Results are published only on the step that enters DONE.
        if (w_last_step) begin
          r_quotient  <= w_quo_nxt;
          r_remainder <= w_rem_nxt;
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
